// File: rtl/adder_tree_pipe_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | adder_tree_pipe_if : valid/ready handshake and data bundle for the       |
// | pipelined adder tree. Revision 1.0                                       |
// +--------------------------------------------------------------------------+
interface adder_tree_pipe_if #(
  parameter int NUM_INPUTS = 9,
  parameter int DATA_WIDTH = 64
);
  logic                             in_valid;
  logic                             in_ready;
  logic [NUM_INPUTS*DATA_WIDTH-1:0] din;
  logic [NUM_INPUTS-1:0]            in_mask;
  logic                             out_valid;
  logic                             out_ready;
  logic [DATA_WIDTH-1:0]            dout;
  logic                             ovf;

  modport master (
    output in_valid, din, in_mask, out_ready,
    input  in_ready, out_valid, dout, ovf
  );

  modport slave (
    input  in_valid, din, in_mask, out_ready,
    output in_ready, out_valid, dout, ovf
  );
endinterface
`default_nettype wire

// File: rtl/adder_tree_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | adder_tree_pipe : pipelined signed N-input adder tree, global stall,     |
// | per-lane mask, overflow flag. ADDER_TREE_SAT_EN selects saturating dout. |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module adder_tree_pipe #(
  parameter int NUM_INPUTS = 9,
  parameter int DATA_WIDTH = 64
) (
  input  logic              clk,
  input  logic              reset,
  adder_tree_pipe_if.slave  bus
);
  localparam int LEVELS = $clog2(NUM_INPUTS);
  localparam int W      = DATA_WIDTH + LEVELS;

  localparam logic [DATA_WIDTH-1:0] C_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] C_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic              advance;
  logic [LEVELS:0]   vld_q;
  logic [LEVELS:0]   vld_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic              ovf_q, ovf_d;
  logic signed [W-1:0] sum;
  logic [LEVELS:0]   top;

  assign advance      = !vld_q[LEVELS] || bus.out_ready;
  assign bus.in_ready = advance;
  assign bus.out_valid = vld_q[LEVELS];
  assign bus.dout     = dout_q;
  assign bus.ovf      = ovf_q;

  // vld_d[i] is the valid bit entering register stage i; stage LEVELS is the output stage
  always_comb begin
    vld_d[0] = bus.in_valid;
    for (int i = 1; i <= LEVELS; i++) begin
      vld_d[i] = vld_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
    end else if (advance) begin
      vld_q <= vld_d;
    end
  end

  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    localparam int CNT = (NUM_INPUTS + (1 << l) - 1) >> l;
    logic signed [W-1:0] node [CNT];

    if (l == 0) begin : g_entry
      for (genvar k = 0; k < CNT; k++) begin : g_lane
        logic signed [DATA_WIDTH-1:0] lane;
        assign lane    = bus.din[k*DATA_WIDTH +: DATA_WIDTH];
        assign node[k] = bus.in_mask[k] ? W'(lane) : '0;
      end
    end else begin : g_reduce
      localparam int PCNT = (NUM_INPUTS + (1 << (l - 1)) - 1) >> (l - 1);
      for (genvar k = 0; k < CNT; k++) begin : g_node
        if (2*k + 1 < PCNT) begin : g_pair
          always_ff @(posedge clk) begin
            if (advance) begin
              node[k] <= g_lvl[l-1].node[2*k] + g_lvl[l-1].node[2*k+1];
            end
          end
        end else begin : g_odd
          always_ff @(posedge clk) begin
            if (advance) begin
              node[k] <= g_lvl[l-1].node[2*k];
            end
          end
        end
      end
    end
  end

  assign sum = g_lvl[LEVELS].node[0];
  // the sum fits DATA_WIDTH exactly when all bits from the result sign bit upward agree
  assign top = sum[W-1:DATA_WIDTH-1];

  always_comb begin
    ovf_d = !((&top) || !(|top));
`ifdef ADDER_TREE_SAT_EN
    dout_d = ovf_d ? (sum[W-1] ? C_MIN : C_MAX) : sum[DATA_WIDTH-1:0];
`else
    dout_d = sum[DATA_WIDTH-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dout_q <= '0;
      ovf_q  <= 1'b0;
    end else if (advance && vld_d[LEVELS]) begin
      dout_q <= dout_d;
      ovf_q  <= ovf_d;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_adder_tree_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_adder_tree_pipe : scoreboard bench for adder_tree_pipe (9x64 and      |
// | 1x16 instances). Revision 1.0                                            |
// +--------------------------------------------------------------------------+
module tb_adder_tree_pipe;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  adder_tree_pipe_if #(.NUM_INPUTS(9), .DATA_WIDTH(64)) bif ();
  adder_tree_pipe_if #(.NUM_INPUTS(1), .DATA_WIDTH(16)) bif1 ();

  adder_tree_pipe #(.NUM_INPUTS(9), .DATA_WIDTH(64)) dut (
    .clk(clk), .reset(reset), .bus(bif)
  );
  adder_tree_pipe #(.NUM_INPUTS(1), .DATA_WIDTH(16)) dut1 (
    .clk(clk), .reset(reset), .bus(bif1)
  );

  localparam logic signed [127:0] LIM_HI = 128'sh7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [127:0] LIM_LO = -128'sh8000_0000_0000_0000;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [64:0] sb [$];
  int pop_cyc [$];
  logic rand_ready  = 1'b0;
  logic force_ready = 1'b1;
  logic prev_stall  = 1'b0;
  logic [64:0] held;

  task automatic chk(input string name, input logic [64:0] got, input logic [64:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: exact sum in 128 bits, then range check and wrap/clamp
  function automatic logic [64:0] model(input logic [575:0] d, input logic [8:0] m);
    logic signed [127:0] s;
    logic signed [63:0]  ln;
    logic                o;
    logic [63:0]         r;
    s = '0;
    for (int k = 0; k < 9; k++) begin
      if (m[k]) begin
        ln = d[k*64 +: 64];
        s  = s + ln;
      end
    end
    o = (s > LIM_HI) || (s < LIM_LO);
    r = s[63:0];
`ifdef ADDER_TREE_SAT_EN
    if (o) r = (s < 0) ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
`endif
    return {o, r};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    bif.out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : force_ready;
  end

  always @(negedge clk) begin
    logic [64:0] got;
    logic [64:0] e;
    got = {bif.ovf, bif.dout};
    chk("in_ready_rule", {64'd0, bif.in_ready}, {64'd0, (!bif.out_valid || bif.out_ready)});
    if (prev_stall) begin
      chk("stall_valid", {64'd0, bif.out_valid}, 65'd1);
      chk("stall_hold", got, held);
    end
    prev_stall = !reset && bif.out_valid && !bif.out_ready;
    held = got;
    if (!reset && bif.out_valid && bif.out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got %h expected none", got);
      end else begin
        e = sb.pop_front();
        chk("result", got, e);
        pop_cyc.push_back(cyc);
      end
    end
  end

  task automatic send(input logic [575:0] d, input logic [8:0] m, input logic [64:0] e,
                      output int acc);
    int n = 0;
    bif.din = d;
    bif.in_mask = m;
    bif.in_valid = 1'b1;
    @(negedge clk);
    while (!bif.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    acc = cyc;
    if (!bif.in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got in_ready=0 expected 1");
    end else begin
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    bif.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [575:0] base_vec();
    logic [575:0] d;
    d = '0;
    for (int k = 0; k < 9; k++) d[k*64 +: 64] = {8'(k + 1), 56'h0};
    return d;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [575:0] d;
    logic [8:0]   m;
    int acc;
    bif.in_valid = 1'b0; bif.din = '0; bif.in_mask = '0;
    bif1.in_valid = 1'b0; bif1.din = '0; bif1.in_mask = '0; bif1.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    chk("reset_out_valid", {64'd0, bif.out_valid}, 65'd0);
    chk("reset_dout_ovf", {bif.ovf, bif.dout}, 65'd0);
    chk("reset_in_ready", {64'd0, bif.in_ready}, 65'd1);
    chk("reset1_out", {bif1.out_valid, bif1.ovf, bif1.dout}, 65'd0);
    @(posedge clk); #1;

    // single transfer and latency
    pop_cyc.delete();
    send(base_vec(), 9'h1FF, {1'b0, 64'h2D00_0000_0000_0000}, acc);
    drain();
    chk("latency", 65'(pop_cyc[0] - acc), 65'd5);

    // three back-to-back transfers
    pop_cyc.delete();
    d = base_vec();
    d[8*64 +: 64] = 64'hF700_0000_0000_0000;
    send(d, 9'h1FF, {1'b0, 64'h1B00_0000_0000_0000}, acc);
    d[4*64 +: 64] = 64'hFEFE_8000_0000_0000;
    send(d, 9'h1FF, {1'b0, 64'h14FE_8000_0000_0000}, acc);
    send(d, 9'h0FF, {1'b0, 64'h1DFE_8000_0000_0000}, acc);
    drain();
    chk("consecutive_1", 65'(pop_cyc[1] - pop_cyc[0]), 65'd1);
    chk("consecutive_2", 65'(pop_cyc[2] - pop_cyc[1]), 65'd1);

    // overflow corners
    for (int k = 0; k < 9; k++) d[k*64 +: 64] = 64'h7FFF_FFFF_FFFF_FFFF;
`ifdef ADDER_TREE_SAT_EN
    send(d, 9'h1FF, {1'b1, 64'h7FFF_FFFF_FFFF_FFFF}, acc);
`else
    send(d, 9'h1FF, {1'b1, 64'h7FFF_FFFF_FFFF_FFF7}, acc);
`endif
    for (int k = 0; k < 9; k++) d[k*64 +: 64] = 64'h8000_0000_0000_0000;
    send(d, 9'h1FF, {1'b1, 64'h8000_0000_0000_0000}, acc);
    drain();

    // random stream with random gaps and backpressure
    rand_ready = 1'b1;
    for (int v = 0; v < 20; v++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      for (int k = 0; k < 9; k++) begin
        if (v % 3 == 0) d[k*64 +: 64] = 64'($signed($urandom_range(0, 2000)) - 1000);
        else d[k*64 +: 64] = {$urandom, $urandom};
      end
      m = 9'($urandom);
      send(d, m, model(d, m), acc);
    end
    rand_ready = 1'b0;
    force_ready = 1'b1;
    drain();

    // reset with a full pipeline and a stalled output
    force_ready = 1'b0;
    @(posedge clk); #1;
    for (int v = 0; v < 5; v++) begin
      for (int k = 0; k < 9; k++) d[k*64 +: 64] = {$urandom, $urandom};
      send(d, 9'h1FF, model(d, 9'h1FF), acc);
    end
    sb.delete();
    bif.din = base_vec();
    bif.in_mask = 9'h1FF;
    bif.in_valid = 1'b1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    bif.in_valid = 1'b0;
    force_ready = 1'b1;
    @(negedge clk);
    chk("midreset_out_valid", {64'd0, bif.out_valid}, 65'd0);
    chk("midreset_dout_ovf", {bif.ovf, bif.dout}, 65'd0);
    repeat (10) @(negedge clk);
    @(posedge clk); #1;
    pop_cyc.delete();
    send(base_vec(), 9'h1FF, {1'b0, 64'h2D00_0000_0000_0000}, acc);
    drain();
    chk("post_reset_latency", 65'(pop_cyc[0] - acc), 65'd5);

    // single-lane instance
    bif1.din = 16'h8001; bif1.in_mask = 1'b1; bif1.in_valid = 1'b1;
    @(negedge clk);
    chk("one_in_ready", {64'd0, bif1.in_ready}, 65'd1);
    @(posedge clk); #1;
    bif1.in_valid = 1'b0;
    @(negedge clk);
    chk("one_lane_pass", {47'd0, bif1.out_valid, bif1.ovf, bif1.dout}, {47'd0, 2'b10, 16'h8001});
    @(posedge clk); #1;
    bif1.in_mask = 1'b0; bif1.in_valid = 1'b1;
    @(posedge clk); #1;
    bif1.in_valid = 1'b0;
    @(negedge clk);
    chk("one_lane_masked", {47'd0, bif1.out_valid, bif1.ovf, bif1.dout}, {47'd0, 2'b10, 16'h0000});
    @(posedge clk); #1;
    @(negedge clk);
    chk("one_lane_bubble", {64'd0, bif1.out_valid}, 65'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
